// File: rtl/sub_seq_pkg.sv
// Shared definitions for the sequential subtractor: default sizes and FSM state encoding.
// Optional feature macro: SUB_BIN_EN (adds a borrow-in input for multi-precision chaining).
package sub_seq_pkg;

  localparam int unsigned DefWidth = 64;
  localparam int unsigned DefChunk = 16;
  localparam int unsigned DefNslice = DefWidth / DefChunk;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/sub_seq_if.sv
// Request/result bundle of the sequential subtractor.
// SUB_BIN_EN adds the bin (borrow-in) request signal.
interface sub_seq_if #(
  parameter int unsigned WIDTH = sub_seq_pkg::DefWidth
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SUB_BIN_EN
  logic             bin;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             borrow;
  logic             zf;
  logic             sf;
  logic             of;

`ifdef SUB_BIN_EN
  modport master (output start, a, b, bin, input busy, done, out, borrow, zf, sf, of);
  modport slave  (input start, a, b, bin, output busy, done, out, borrow, zf, sf, of);
`else
  modport master (output start, a, b, input busy, done, out, borrow, zf, sf, of);
  modport slave  (input start, a, b, output busy, done, out, borrow, zf, sf, of);
`endif

endinterface

// File: rtl/sub_seq_chunk.sv
// Combinational CHUNK-bit subtract with borrow-in: diff = a - b - bin.
module sub_seq_chunk #(
  parameter int unsigned CHUNK = sub_seq_pkg::DefChunk
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             bin_i,
  output logic [CHUNK-1:0] diff_o,
  output logic             bout_o
);

  logic [CHUNK:0] full;

  // One extra bit: a negative result leaves the top bit set, which is the borrow-out.
  always_comb begin
    full   = {1'b0, a_i} - {1'b0, b_i} - {{CHUNK{1'b0}}, bin_i};
    diff_o = full[CHUNK-1:0];
    bout_o = full[CHUNK];
  end

endmodule

// File: rtl/sub_seq.sv
// Multi-cycle subtractor: out = a - b, CHUNK bits per cycle, LS slice first.
// Produces Y86-style ZF/SF/OF plus unsigned borrow, valid on the one-cycle done pulse.
// Optional macro SUB_BIN_EN: latch a borrow-in (bin) with the operands to seed the ripple.
module sub_seq
  import sub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CHUNK = DefChunk
) (
  input logic          clk,
  input logic          rst_n,
  sub_seq_if.slave     sub_if
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             borrow_q, borrow_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;

  logic [CHUNK-1:0] slice_a, slice_b, slice_diff;
  logic             slice_bout;

  // Operand slice for the current counter value feeds the single shared slice subtractor.
  always_comb begin
    slice_a = a_q[cnt_q*CHUNK +: CHUNK];
    slice_b = b_q[cnt_q*CHUNK +: CHUNK];
  end

  sub_seq_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .bin_i  (brw_q),
    .diff_o (slice_diff),
    .bout_o (slice_bout)
  );

  // Next-state logic: accept in idle, ripple one slice per run cycle, pulse done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    brw_d    = brw_q;
    out_d    = out_q;
    borrow_d = borrow_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    of_d     = of_q;

    unique case (state_q)
      StIdle: begin
        if (sub_if.start) begin
          a_d     = sub_if.a;
          b_d     = sub_if.b;
`ifdef SUB_BIN_EN
          brw_d   = sub_if.bin;
`else
          brw_d   = 1'b0;
`endif
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        out_d[cnt_q*CHUNK +: CHUNK] = slice_diff;
        brw_d = slice_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          // Flags are registered on entry to DONE so they line up with the done pulse.
          borrow_d = slice_bout;
          zf_d     = (out_d == '0);
          sf_d     = out_d[WIDTH-1];
          of_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (out_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      brw_q    <= 1'b0;
      out_q    <= '0;
      borrow_q <= 1'b0;
      zf_q     <= 1'b0;
      sf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      brw_q    <= brw_d;
      out_q    <= out_d;
      borrow_q <= borrow_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      of_q     <= of_d;
    end
  end

  // Status and result outputs straight from registered state.
  always_comb begin
    sub_if.busy   = (state_q != StIdle);
    sub_if.done   = (state_q == StDone);
    sub_if.out    = out_q;
    sub_if.borrow = borrow_q;
    sub_if.zf     = zf_q;
    sub_if.sf     = sf_q;
    sub_if.of     = of_q;
  end

endmodule

// File: tb/tb_sub_seq.sv
// Directed self-checking bench for sub_seq (default build, 64-bit / 16-bit slices).
module tb_sub_seq;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  sub_seq_if #(.WIDTH(64)) bus ();

  sub_seq #(
    .WIDTH (64),
    .CHUNK (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sub_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] r_out;
  logic        r_brw, r_zf, r_sf, r_of;
  int          r_lat, r_busy;

  // Launch one operation and wait (bounded) for done; returns results, latency, busy cycles.
  task automatic do_op(input logic [63:0] av, input logic [63:0] bv);
    bit seen;
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    r_lat  = 0;
    r_busy = 0;
    seen   = 1'b0;
    while (!seen && r_lat < 20) begin
      @(negedge clk);
      bus.start = 1'b0;
      r_lat++;
      if (bus.busy) r_busy++;
      if (bus.done) seen = 1'b1;
    end
    r_out = bus.out;
    r_brw = bus.borrow;
    r_zf  = bus.zf;
    r_sf  = bus.sf;
    r_of  = bus.of;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SUB_BIN_EN
    bus.bin   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.out, bus.borrow, bus.zf, bus.sf, bus.of} !== 70'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b out=%h brw=%b zf=%b sf=%b of=%b want all 0",
               bus.busy, bus.done, bus.out, bus.borrow, bus.zf, bus.sf, bus.of);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.done, bus.out} !== 66'd0) begin
      n_bad++;
      $display("FAIL reset_release_idle: got busy=%b done=%b out=%h want 0 0 0",
               bus.busy, bus.done, bus.out);
    end
  endtask

  task automatic test_equal;
    do_op(64'd1023, 64'd1023);
    n_cmp++;
    if (r_lat !== 5) begin
      n_bad++;
      $display("FAIL equal_latency: got %0d want 5", r_lat);
    end
    n_cmp++;
    if (r_busy !== 5) begin
      n_bad++;
      $display("FAIL equal_busy_cycles: got %0d want 5", r_busy);
    end
    n_cmp++;
    if ({r_out, r_brw, r_zf, r_sf, r_of} !== {64'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL equal_result: got out=%h brw=%b zf=%b sf=%b of=%b want 0 0 1 0 0",
               r_out, r_brw, r_zf, r_sf, r_of);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL equal_done_one_cycle: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_wrap;
    do_op(64'd0, 64'd1);
    n_cmp++;
    if ({r_out, r_brw, r_zf, r_sf, r_of} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL wrap_0_minus_1: got out=%h brw=%b zf=%b sf=%b of=%b want ffffffffffffffff 1 0 1 0",
               r_out, r_brw, r_zf, r_sf, r_of);
    end
  endtask

  task automatic test_overflow;
    do_op(64'h8000_0000_0000_0000, 64'd1);
    n_cmp++;
    if ({r_out, r_brw, r_zf, r_sf, r_of} !== {64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL signed_overflow: got out=%h brw=%b zf=%b sf=%b of=%b want 7fffffffffffffff 0 0 0 1",
               r_out, r_brw, r_zf, r_sf, r_of);
    end
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    n_cmp++;
    if ({r_out, r_brw, r_zf, r_sf, r_of} !== {64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL pos_overflow: got out=%h brw=%b zf=%b sf=%b of=%b want 8000000000000000 1 0 1 1",
               r_out, r_brw, r_zf, r_sf, r_of);
    end
  endtask

  task automatic test_ripple;
    do_op(64'h0001_0000_0000_0000, 64'd1);
    n_cmp++;
    if ({r_out, r_brw, r_zf, r_sf, r_of} !== {64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL slice_ripple: got out=%h brw=%b zf=%b sf=%b of=%b want 0000ffffffffffff 0 0 0 0",
               r_out, r_brw, r_zf, r_sf, r_of);
    end
  endtask

  task automatic test_start_held;
    int          dones;
    logic [63:0] out_at_done;
    dones       = 0;
    out_at_done = '0;
    @(negedge clk);
    bus.a = 64'd5; bus.b = 64'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 64'd100; bus.b = 64'd1;
    if (bus.done) begin dones++; out_at_done = bus.out; end
    @(negedge clk);
    bus.a = 64'd7; bus.b = 64'd9;
    if (bus.done) begin dones++; out_at_done = bus.out; end
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done) begin dones++; out_at_done = bus.out; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) begin dones++; out_at_done = bus.out; end
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++;
      $display("FAIL start_held_done_count: got %0d want 1", dones);
    end
    n_cmp++;
    if (out_at_done !== 64'd2) begin
      n_bad++;
      $display("FAIL start_held_result: got %h want 2", out_at_done);
    end
  endtask

  task automatic test_back_to_back;
    int          cyc;
    int          first_done, second_done;
    logic [63:0] out1, out2;
    first_done  = -1;
    second_done = -1;
    out1 = '0;
    out2 = '0;
    @(negedge clk);
    bus.a = 64'd50; bus.b = 64'd20; bus.start = 1'b1;
    for (cyc = 1; cyc <= 20 && second_done < 0; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first_done < 0) begin
          first_done = cyc;
          out1 = bus.out;
          bus.a = 64'd3; bus.b = 64'd10;
        end else begin
          second_done = cyc;
          out2 = bus.out;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (first_done !== 5 || second_done !== 11) begin
      n_bad++;
      $display("FAIL b2b_timing: got done at %0d,%0d want 5,11", first_done, second_done);
    end
    n_cmp++;
    if (out1 !== 64'd30 || out2 !== 64'hFFFF_FFFF_FFFF_FFF9) begin
      n_bad++;
      $display("FAIL b2b_results: got %h,%h want 1e,fffffffffffffff9", out1, out2);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int dones;
    dones = 0;
    @(negedge clk);
    bus.a = 64'd1000; bus.b = 64'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.out, bus.borrow, bus.zf, bus.sf, bus.of} !== 70'd0) begin
      n_bad++;
      $display("FAIL reset_mid_op: got busy=%b done=%b out=%h flags=%b%b%b%b want all 0",
               bus.busy, bus.done, bus.out, bus.borrow, bus.zf, bus.sf, bus.of);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: got %0d active cycles want 0", dones);
    end
    do_op(64'd9, 64'd4);
    n_cmp++;
    if (r_out !== 64'd5 || r_lat !== 5) begin
      n_bad++;
      $display("FAIL reset_recover: got out=%h lat=%0d want 5 5", r_out, r_lat);
    end
  endtask

  task automatic test_sweep;
    logic [63:0] ea, eb, ex;
    logic        eb_r, ez, es, eo;
    for (int bi = 1023; bi >= 1008; bi--) begin
      for (int ai = 1022; ai >= 1007; ai--) begin
        ea = 64'(ai);
        eb = 64'(bi);
        do_op(ea, eb);
        ex   = ea - eb;
        eb_r = (ea < eb);
        ez   = (ex == 64'd0);
        es   = ex[63];
        eo   = (ea[63] != eb[63]) && (ex[63] != ea[63]);
        n_cmp++;
        if ({r_out, r_brw, r_zf, r_sf, r_of, r_lat} !== {ex, eb_r, ez, es, eo, 32'sd5}) begin
          n_bad++;
          $display("FAIL sweep a=%0d b=%0d: got out=%h brw=%b zf=%b sf=%b of=%b lat=%0d want %h %b %b %b %b 5",
                   ai, bi, r_out, r_brw, r_zf, r_sf, r_of, r_lat, ex, eb_r, ez, es, eo);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_equal();
    test_wrap();
    test_overflow();
    test_ripple();
    test_start_held();
    test_back_to_back();
    test_reset_mid_op();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
